// File: rtl/dram_cmd_scheduler_pkg.sv
// Shared types, address-map constants and default DDR4 timings for the
// in-order DRAM command scheduler.
package global_defs;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4
    } dram_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECIDE,
        ST_PRECHARGE,
        ST_ACTIVATE,
        ST_COLUMN,
        ST_WAIT,
        ST_DONE
    } sched_state_t;

    typedef enum logic [1:0] {
        OP_READ     = 2'd0,
        OP_WRITE    = 2'd1,
        OP_IFETCH   = 2'd2,
        OP_READ_ALT = 2'd3
    } operation_t;

    localparam int ADDR_W     = 33;
    localparam int ROW_W      = 15;
    localparam int COL_HI_W   = 8;
    localparam int COL_LO_W   = 3;
    localparam int COL_W      = COL_HI_W + COL_LO_W;
    localparam int BANK_W     = 2;
    localparam int BG_W       = 2;
    localparam int BANK_IDX_W = BG_W + BANK_W;
    localparam int NUM_BANKS  = 1 << BANK_IDX_W;
    localparam int CMD_ADDR_W = 15;
    localparam int PRE_CNT_W  = 8;
    localparam int WAIT_W     = 8;

    localparam int ROW_LSB    = 18;
    localparam int COL_HI_LSB = 10;
    localparam int BANK_LSB   = 8;
    localparam int BG_LSB     = 6;
    localparam int COL_LO_LSB = 3;

    typedef struct packed {
        logic                 open;
        logic [ROW_W-1:0]     row;
        logic [PRE_CNT_W-1:0] pre_cnt;
    } bank_entry_t;

    // Timings in controller clocks (one DIMM clock = two controller clocks).
    localparam int DEF_T_RCD   = 48;
    localparam int DEF_T_RP    = 48;
    localparam int DEF_T_CL    = 48;
    localparam int DEF_T_CWL   = 40;
    localparam int DEF_T_RAS   = 104;
    localparam int DEF_T_RTP   = 24;
    localparam int DEF_T_WR    = 40;
    localparam int DEF_T_BURST = 8;

endpackage

// File: rtl/dram_cmd_scheduler_bank.sv
// Per-bank open-row state and PRE-legality counters for all 16 banks.
module bank_table
    import global_defs::*;
#(
    parameter int T_RAS    = DEF_T_RAS,
    parameter int T_RTP    = DEF_T_RTP,
    parameter int T_WR_PRE = DEF_T_CWL + DEF_T_BURST + DEF_T_WR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BANK_IDX_W-1:0] rd_idx,
    output bank_entry_t           rd_entry,
    input  logic                  upd_valid,
    input  logic [2:0]            upd_cmd,
    input  logic [BANK_IDX_W-1:0] upd_idx,
    input  logic [ROW_W-1:0]      upd_row
);

    localparam logic [PRE_CNT_W-1:0] RAS_LD = PRE_CNT_W'(T_RAS);
    localparam logic [PRE_CNT_W-1:0] RTP_LD = PRE_CNT_W'(T_RTP);
    localparam logic [PRE_CNT_W-1:0] WR_LD  = PRE_CNT_W'(T_WR_PRE);

    bank_entry_t entries [NUM_BANKS];

    function automatic logic [PRE_CNT_W-1:0] load_max(
        input logic [PRE_CNT_W-1:0] cur,
        input logic [PRE_CNT_W-1:0] floor_v
    );
        return (cur > floor_v) ? cur : floor_v;
    endfunction

    function automatic logic [PRE_CNT_W-1:0] sat_dec(input logic [PRE_CNT_W-1:0] cur);
        return (cur != '0) ? cur - PRE_CNT_W'(1) : '0;
    endfunction

    assign rd_entry = entries[rd_idx];

    // A load replaces the decrement in its cycle; RD/WR never shorten an existing hold.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (upd_valid && upd_idx == BANK_IDX_W'(i) && upd_cmd == CMD_ACT) begin
                entries[i].row <= upd_row;
            end
            if (rst) begin
                entries[i].open    <= 1'b0;
                entries[i].pre_cnt <= '0;
            end else if (upd_valid && upd_idx == BANK_IDX_W'(i)) begin
                case (upd_cmd)
                    CMD_ACT: begin
                        entries[i].open    <= 1'b1;
                        entries[i].pre_cnt <= RAS_LD;
                    end
                    CMD_RD:  entries[i].pre_cnt <= load_max(entries[i].pre_cnt, RTP_LD);
                    CMD_WR:  entries[i].pre_cnt <= load_max(entries[i].pre_cnt, WR_LD);
                    CMD_PRE: begin
                        entries[i].open    <= 1'b0;
                        entries[i].pre_cnt <= sat_dec(entries[i].pre_cnt);
                    end
                    default: entries[i].pre_cnt <= sat_dec(entries[i].pre_cnt);
                endcase
            end else begin
                entries[i].pre_cnt <= sat_dec(entries[i].pre_cnt);
            end
        end
    end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// In-order DDR4 command scheduler: decodes one queued request at a time and
// issues the PRE/ACT/RD/WR sequence it needs under an open-page policy.
module dram_cmd_scheduler
    import global_defs::*;
#(
    parameter int T_RCD   = DEF_T_RCD,
    parameter int T_RP    = DEF_T_RP,
    parameter int T_CL    = DEF_T_CL,
    parameter int T_CWL   = DEF_T_CWL,
    parameter int T_RAS   = DEF_T_RAS,
    parameter int T_RTP   = DEF_T_RTP,
    parameter int T_WR    = DEF_T_WR,
    parameter int T_BURST = DEF_T_BURST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [1:0]            req_op,
    input  logic [ADDR_W-1:0]     req_addr,
    output logic                  req_ready,
    output logic                  cmd_valid,
    output logic [2:0]            cmd,
    output logic [BG_W-1:0]       cmd_bg,
    output logic [BANK_W-1:0]     cmd_bank,
    output logic [CMD_ADDR_W-1:0] cmd_addr,
    output logic                  done,
    output logic                  busy
);

    // WAIT spans N-1 cycles so the next command lands exactly N cycles after
    // the previous one; the counter runs down to zero inclusive, hence N-2.
    localparam logic [WAIT_W-1:0] RP_WAIT  = WAIT_W'(T_RP - 2);
    localparam logic [WAIT_W-1:0] RCD_WAIT = WAIT_W'(T_RCD - 2);
    localparam logic [WAIT_W-1:0] RD_WAIT  = WAIT_W'(T_CL + T_BURST - 2);
    localparam logic [WAIT_W-1:0] WR_WAIT  = WAIT_W'(T_CWL + T_BURST - 2);

    sched_state_t          state, state_nxt, ret_state, ret_nxt;
    logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
    operation_t            op_q;
    logic [ROW_W-1:0]      row_q;
    logic [COL_W-1:0]      col_q;
    logic [BG_W-1:0]       bg_q;
    logic [BANK_W-1:0]     bank_q;
    dram_cmd_t             cmd_d;
    bank_entry_t           cur_entry;
    logic                  accept;
    logic                  is_write;
    logic                  row_hit;
    logic                  unused_byte;

    assign accept      = req_valid && req_ready;
    assign is_write    = (op_q == OP_WRITE);
    assign row_hit     = cur_entry.open && (cur_entry.row == row_q);
    assign unused_byte = ^req_addr[COL_LO_LSB-1:0];
    assign busy        = (state != ST_IDLE);
    assign cmd         = cmd_d;

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= operation_t'(req_op);
            row_q  <= req_addr[ROW_LSB +: ROW_W];
            col_q  <= {req_addr[COL_HI_LSB +: COL_HI_W], req_addr[COL_LO_LSB +: COL_LO_W]};
            bank_q <= req_addr[BANK_LSB +: BANK_W];
            bg_q   <= req_addr[BG_LSB +: BG_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ret_state <= ST_IDLE;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            wait_cnt  <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_state;
        wait_nxt  = wait_cnt;
        req_ready = 1'b0;
        done      = 1'b0;
        cmd_d     = CMD_NOP;
        cmd_valid = 1'b0;
        cmd_bg    = '0;
        cmd_bank  = '0;
        cmd_addr  = '0;
        unique case (state)
            ST_IDLE: begin
                req_ready = req_valid;
                if (req_valid) state_nxt = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (row_hit)                state_nxt = ST_COLUMN;
                else if (!cur_entry.open)   state_nxt = ST_ACTIVATE;
                else                        state_nxt = ST_PRECHARGE;
            end
            ST_PRECHARGE: begin
                if (cur_entry.pre_cnt == '0) begin
                    cmd_d     = CMD_PRE;
                    cmd_valid = 1'b1;
                    cmd_bg    = bg_q;
                    cmd_bank  = bank_q;
                    wait_nxt  = RP_WAIT;
                    ret_nxt   = ST_ACTIVATE;
                    state_nxt = ST_WAIT;
                end
            end
            ST_ACTIVATE: begin
                cmd_d     = CMD_ACT;
                cmd_valid = 1'b1;
                cmd_bg    = bg_q;
                cmd_bank  = bank_q;
                cmd_addr  = row_q;
                wait_nxt  = RCD_WAIT;
                ret_nxt   = ST_COLUMN;
                state_nxt = ST_WAIT;
            end
            ST_COLUMN: begin
                cmd_d     = is_write ? CMD_WR : CMD_RD;
                cmd_valid = 1'b1;
                cmd_bg    = bg_q;
                cmd_bank  = bank_q;
                cmd_addr  = CMD_ADDR_W'(col_q);
                wait_nxt  = is_write ? WR_WAIT : RD_WAIT;
                ret_nxt   = ST_DONE;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == '0) state_nxt = ret_state;
                else                wait_nxt  = wait_cnt - WAIT_W'(1);
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    bank_table #(
        .T_RAS    (T_RAS),
        .T_RTP    (T_RTP),
        .T_WR_PRE (T_CWL + T_BURST + T_WR)
    ) u_bank_table (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    ({bg_q, bank_q}),
        .rd_entry  (cur_entry),
        .upd_valid (cmd_valid),
        .upd_cmd   (cmd_d),
        .upd_idx   ({bg_q, bank_q}),
        .upd_row   (row_q)
    );

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Directed bench for dram_cmd_scheduler: row miss, hit, conflict, tWR-stalled
// precharge, op encodings and mid-request reset.
module tb_dram_cmd_scheduler;
    import global_defs::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [32:0] req_addr;
    logic        req_ready;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_bank;
    logic [14:0] cmd_addr;
    logic        done;
    logic        busy;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    dram_cmd_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_bg    (cmd_bg),
        .cmd_bank  (cmd_bank),
        .cmd_addr  (cmd_addr),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [32:0] addr, output int a);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        #1;
        a = cyc;
        chk("accept.ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = 33'($urandom);
    endtask

    task automatic wait_evt(output int c);
        int n;
        n = 0;
        step();
        while (!(cmd_valid || done) && n < 400) begin
            step();
            n++;
        end
        c = (cmd_valid || done) ? cyc : -1;
    endtask

    task automatic expect_cmd(input string tag, input int base, input int off,
                              input logic [2:0] ec, input logic [1:0] ebg,
                              input logic [1:0] ebank, input logic [14:0] ea,
                              output int c);
        wait_evt(c);
        chk({tag, ".cyc"},   32'(c - base), 32'(off));
        chk({tag, ".valid"}, 32'(cmd_valid), 32'd1);
        chk({tag, ".cmd"},   32'(cmd), 32'(ec));
        chk({tag, ".bg"},    32'(cmd_bg), 32'(ebg));
        chk({tag, ".bank"},  32'(cmd_bank), 32'(ebank));
        chk({tag, ".addr"},  32'(cmd_addr), 32'(ea));
    endtask

    task automatic expect_done(input string tag, input int base, input int off);
        int c;
        wait_evt(c);
        chk({tag, ".cyc"},   32'(c - base), 32'(off));
        chk({tag, ".pulse"}, 32'(done), 32'd1);
        chk({tag, ".nocmd"}, 32'(cmd_valid), 32'd0);
        step();
        chk({tag, ".idle"},  32'(busy), 32'd0);
        chk({tag, ".once"},  32'(done), 32'd0);
    endtask

    initial begin
        int a, c, w, p, ndone;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_addr  = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst.cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst.cmd",       32'(cmd), 32'(CMD_NOP));
        chk("rst.addr",      32'(cmd_addr), 32'd0);
        chk("rst.done",      32'(done), 32'd0);
        chk("rst.busy",      32'(busy), 32'd0);
        chk("rst.ready",     32'(req_ready), 32'd0);

        // Closed-bank read, bank group 1
        issue(2'd0, 33'h0_0000_0040, a);
        expect_cmd("s1.act", a, 2, CMD_ACT, 2'd1, 2'd0, 15'd0, c);
        chk("s1.busy", 32'(busy), 32'd1);
        expect_cmd("s1.rd", a, 50, CMD_RD, 2'd1, 2'd0, 15'd0, c);
        expect_done("s1.done", a, 106);

        // Row hit, column 8
        issue(2'd0, 33'h0_0000_0440, a);
        expect_cmd("s2.rd", a, 2, CMD_RD, 2'd1, 2'd0, 15'd8, c);
        expect_done("s2.done", a, 58);

        // Write, row conflict (row 1)
        issue(2'd1, 33'h0_0004_0040, a);
        expect_cmd("s3.pre", a, 2, CMD_PRE, 2'd1, 2'd0, 15'd0, c);
        req_valid = 1'b1;
        req_addr  = 33'h1_2345_6789;
        #1;
        chk("s3.ready_busy", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        expect_cmd("s3.act", a, 50, CMD_ACT, 2'd1, 2'd0, 15'd1, c);
        expect_cmd("s3.wr", a, 98, CMD_WR, 2'd1, 2'd0, 15'd0, w);
        expect_done("s3.done", w, 48);

        // Read, row conflict right after the write: PRE held by write recovery
        issue(2'd0, 33'h0_0008_0040, a);
        chk("s4.accept", 32'(a - w), 32'd49);
        expect_cmd("s4.pre", w, 89, CMD_PRE, 2'd1, 2'd0, 15'd0, p);
        expect_cmd("s4.act", p, 48, CMD_ACT, 2'd1, 2'd0, 15'd2, c);
        expect_cmd("s4.rd", p, 96, CMD_RD, 2'd1, 2'd0, 15'd0, c);
        expect_done("s4.done", c, 56);

        // op 3 behaves as read; row hit, column 1
        issue(2'd3, 33'h0_0008_0048, a);
        expect_cmd("s5.rd", a, 2, CMD_RD, 2'd1, 2'd0, 15'd1, c);
        expect_done("s5.done", a, 58);

        // Ifetch to bg 3 bank 2 row 5
        issue(2'd2, 33'h0_0014_02C0, a);
        expect_cmd("s6.act", a, 2, CMD_ACT, 2'd3, 2'd2, 15'd5, c);
        expect_cmd("s6.rd", a, 50, CMD_RD, 2'd3, 2'd2, 15'd0, c);
        expect_done("s6.done", a, 106);

        // Reset during the wait after ACT
        issue(2'd0, 33'h0_0000_0100, a);
        expect_cmd("s7.act", a, 2, CMD_ACT, 2'd0, 2'd1, 15'd0, c);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s7.rst.valid", 32'(cmd_valid), 32'd0);
        chk("s7.rst.cmd",   32'(cmd), 32'(CMD_NOP));
        chk("s7.rst.bank",  32'(cmd_bank), 32'd0);
        chk("s7.rst.done",  32'(done), 32'd0);
        chk("s7.rst.busy",  32'(busy), 32'd0);
        chk("s7.rst.ready", 32'(req_ready), 32'd0);
        ndone = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (done || cmd_valid) ndone++;
        end
        chk("s7.no_done", 32'(ndone), 32'd0);
        issue(2'd0, 33'h0_0000_0100, a);
        expect_cmd("s7.react", a, 2, CMD_ACT, 2'd0, 2'd1, 15'd0, c);
        expect_cmd("s7.rd", a, 50, CMD_RD, 2'd0, 2'd1, 15'd0, c);
        expect_done("s7.done", a, 106);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_cmd_scheduler.md
# dram_cmd_scheduler

In-order DDR4 command scheduler between the request queue and the DRAM command output. Pops one request at a time from the queue head, decodes its address into bank group, bank, row and column, and tracks open rows per bank under an open-page policy. Issues the PRE/ACT/RD/WR sequence that request needs while enforcing per-bank and command-to-command timing, then pulses `done` when the data burst completes.

## Interface
- `T_RCD`, 48: ACT to RD/WR delay, in clk cycles (all timings in clk; 1 DIMM clock = 2 clk)
- `T_RP`, 48: PRE to ACT, same bank
- `T_CL`, 48: RD to first data
- `T_CWL`, 40: WR to first data
- `T_RAS`, 104: ACT to PRE, same bank
- `T_RTP`, 24: RD to PRE, same bank
- `T_WR`, 40: end of write burst to PRE, same bank
- `T_BURST`, 8: data burst length
- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 1: queue head holds a request
- `req_op` in 2: `operation_t`; 0 read, 1 write, 2 ifetch, 3 treated as read
- `req_addr` in 33: physical byte address
- `req_ready` out 1: request accepted this cycle; the queue pops on `req_valid && req_ready`
- `cmd_valid` out 1: `cmd` is valid this cycle
- `cmd` out 3: `dram_cmd_t` (NOP, ACT, RD, WR, PRE)
- `cmd_bg` out 2: bank group
- `cmd_bank` out 2: bank
- `cmd_addr` out 15: row for ACT; zero-extended 11-bit column for RD/WR; 0 for PRE
- `done` out 1: one-cycle pulse when the current request's burst completes
- `busy` out 1: a request is in flight

## Operation
- Address map: row [32:18], column high [17:10], bank [9:8], bank group [7:6], column low [5:3], byte [2:0] ignored. Column = {col_high, col_low}.
- Bank table: 16 entries, one per bank. Each entry holds `open` (1), `row` (15) and `pre_cnt` (8).
- `pre_cnt` decrements each cycle and saturates at 0. A PRE to a bank is legal only when its `pre_cnt` is 0.
- `pre_cnt` loading: on ACT, load `T_RAS`. On RD, load max(cur, `T_RTP`). On WR, load max(cur, `T_CWL+T_BURST+T_WR`).
- FSM states:
  - IDLE: `req_ready = req_valid`. On transfer, latch op and decoded fields, go to DECIDE.
  - DECIDE: row hit (open and row matches) goes to COLUMN. Bank closed goes to ACTIVATE. Row conflict goes to PRECHARGE.
  - PRECHARGE: wait while `pre_cnt != 0`. Otherwise issue PRE, clear `open`, load wait = `T_RP`, go to WAIT.
  - ACTIVATE: issue ACT, set `open` and `row`, load wait = `T_RCD`, go to WAIT.
  - COLUMN: issue RD (read or ifetch) or WR, load wait = `T_CL+T_BURST` (read) or `T_CWL+T_BURST` (write), go to WAIT.
  - WAIT: count down. At the end, return to the next step of the sequence (after PRE go to ACTIVATE, after ACT go to COLUMN, after the column command go to DONE).
  - DONE: pulse `done`, go to IDLE.
- DECIDE, PRECHARGE, ACTIVATE and COLUMN issue with no idle cycle between a state change and the command, so a command is issued in the first cycle the state is legal.
- At most one command per cycle. When no command is issued: `cmd=NOP`, `cmd_valid=0`, all address fields 0.
- `busy` = state != IDLE.

## Timing
- Reset: every output is 0 and `cmd=NOP`. FSM goes to IDLE, all banks closed, all `pre_cnt`=0.
- Reset mid-request aborts the request with no `done`.
- The request is accepted in cycle A. The first command is issued at A+2 (DECIDE at A+1 selects it; the issuing state is registered in the same step).
- Read, closed bank: ACT at A+2, RD at A+2+`T_RCD`, `done` at RD+`T_CL+T_BURST`.
- A wait of N means the next command is issued exactly N cycles after the previous one.
- The PRE in a row conflict may be stalled by `pre_cnt`. The stall extends the latency 1:1.
- `req_ready` is never asserted outside IDLE. `req_valid` dropping while not ready has no effect.
- `req_op`/`req_addr` are sampled only on transfer and ignored at all other times.
- `done` and `req_ready` are never asserted in the same cycle; IDLE starts the cycle after DONE.

## Structure
- `global_defs` package gets:
  - `dram_cmd_t` (3-bit enum)
  - `sched_state_t`
  - `operation_t`
  - address field widths/positions
  - `bank_entry_t`
  - default timing constants
- Sub-module `bank_table`: holds the 16 entries with `pre_cnt` decrement and max-load logic. It has a read port indexed by {bg, bank} and an update port (cmd, bank index, row).
- The FSM, wait counter and address decode stay in `dram_cmd_scheduler`.

## Test plan
- Reset, then read at 0x0_0000_0040 (bank group 1) accepted at cycle A → ACT bg=1 bank=0 row=0 at A+2. RD col=0 at A+50. `done` at A+106.
- Repeat a read to the same row, different column (addr 0x0_0000_0440) → RD col=8 issued 2 cycles after accept with no ACT.
- Write to a different row in the same bank, issued right after the previous two → PRE is held until `T_RAS` from the first ACT has expired. Then ACT 48 cycles after PRE, WR 48 cycles after ACT, `done` 48 cycles after WR.
- Read after a write to the same bank with a row conflict → PRE no earlier than WR+88.
- `req_op`=3 behaves identically to a read. Ifetch emits RD.
- Assert `rst` during WAIT after ACT → next cycle all outputs are 0 and there is no `done`. The same address is then a closed-bank miss again (ACT issued).
